keycode_servo_driver: RTL and testbench
=======================================

KEYCODE_SERVO_DRIVER -- requirements
Module: keycode_servo_driver

Interface
REQ-001 The block SHALL have parameter FRAME_CYC, default 1000000, servo frame length in iCLK cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter MIN_CYC, default 50000, pulse width in cycles at position 0.
REQ-003 The block SHALL have parameter STEP_CYC, default 250, added pulse cycles per position unit.
REQ-004 The block SHALL have parameter RAMP_STEP, default 4, maximum position change per frame.
REQ-005 The block SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port iRST_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port iKeyCode, input, 8 bits: sticky key code from the PS/2 controller stage.
REQ-008 The block SHALL have port oPWM, output, 1 bit: servo pulse, high at the start of each frame.
REQ-009 The block SHALL have port oPos, output, 8 bits: current position, range 0..200.
REQ-010 The block SHALL have port oDir, output, 2 bits: 00 idle, 01 ramping left, 10 ramping right.
REQ-011 The block SHALL have port oBusy, output, 1 bit: high whenever oPos != target.

Function
REQ-012 iKeyCode SHALL be registered once (key_q); target SHALL update the cycle after key_q changes.
REQ-013 Decode: key_q 8'h6B -> target 0; 8'h74 -> target 200; 8'h00 -> target 100; any other value -> target unchanged.
REQ-014 frame_cnt SHALL count 0..FRAME_CYC-1 and wrap to 0; frame_end is the cycle in which frame_cnt == FRAME_CYC-1.
REQ-015 Position SHALL change only on frame_end.
- If target > pos: pos += min(RAMP_STEP, target-pos).
- If target < pos: pos -= min(RAMP_STEP, pos-target).
- Never overshoots target; never leaves 0..200.
REQ-016 At frame_end, width_q SHALL load MIN_CYC + next_pos*STEP_CYC.
- Computed at full width (>= 20 bits) with no truncation.
- width_q is constant for the whole following frame, so a pulse never glitches mid-frame.
REQ-017 oPWM SHALL be registered and equal (frame_cnt < width_q), so a frame with width W gives exactly W high cycles followed by FRAME_CYC-W low cycles.
REQ-018 FSM states SHALL be IDLE, RAMP_L and RAMP_R, evaluated every cycle from target versus pos.
- IDLE when equal.
- RAMP_L when target < pos.
- RAMP_R when target > pos.
- oDir SHALL encode the state per REQ-010.
REQ-019 A target reversal mid-ramp SHALL switch the FSM immediately; the position reverses direction at the next frame_end.
REQ-020 A key change landing on the same cycle as frame_end SHALL NOT affect that frame_end's step; the step uses the old target.
REQ-021 oBusy SHALL equal (state != IDLE).

Reset
REQ-022 While iRST_n is low, all of the following SHALL hold asynchronously:
- key_q = 0, target = 100, pos = 100, frame_cnt = 0, width_q = MIN_CYC + 100*STEP_CYC.
- FSM = IDLE; oPWM = 0, oPos = 100, oDir = 00, oBusy = 0.
REQ-023 Reset asserted mid-frame or mid-ramp SHALL abort the frame immediately; the first frame after release starts at frame_cnt = 0 with centre width.
REQ-024 Deassertion SHALL be synchronized to iCLK; the first count occurs on the second rising edge after release.

Verification
REQ-025 The bench SHALL use FRAME_CYC=400, MIN_CYC=50, STEP_CYC=1, RAMP_STEP=4.
REQ-026 Reset release, iKeyCode=0 -> oPWM high for 150 cycles and low for 250 cycles each frame; oPos=100; oDir=00.
REQ-027 iKeyCode=8'h74 -> oDir=10 two cycles later; oPos goes 104, 108, ..., 200 on successive frame_ends (25 frames); width reaches 250; then oDir=00, oBusy=0.
REQ-028 At oPos=120 while ramping right, iKeyCode=8'h6B -> oDir=01 within 2 cycles; the next frame_end gives oPos=116; ramping continues to 0 with width 50.
REQ-029 RAMP_STEP=7, ramp from 100 toward 0 -> oPos goes 93, ..., 9, 2, 0 with no underflow; the final step is 2.
REQ-030 iKeyCode=8'h12 during a ramp -> target unchanged and the ramp continues; iRST_n pulsed low at frame_cnt=200 -> oPWM=0 immediately, oPos=100, and the next frame has width 150.

Source files
------------

// File: rtl/keycode_servo_driver_if.sv
// Key-code input and servo status outputs of keycode_servo_driver, bundled
// so a bench or parent can carry them as one object.
interface keycode_servo_driver_if;
  logic [7:0] iKeyCode;
  logic       oPWM;
  logic [7:0] oPos;
  logic [1:0] oDir;
  logic       oBusy;

  modport master (output iKeyCode, input oPWM, oPos, oDir, oBusy);
  modport slave  (input iKeyCode, output oPWM, oPos, oDir, oBusy);
endinterface

// File: rtl/keycode_servo_driver.sv
// Hobby-servo PWM driver: a PS/2 key code selects a target position and the
// pulse width ramps toward it by at most RAMP_STEP units per servo frame.
module keycode_servo_driver #(
  parameter int unsigned FRAME_CYC = 1000000,
  parameter int unsigned MIN_CYC   = 50000,
  parameter int unsigned STEP_CYC  = 250,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [7:0] iKeyCode,
  output logic       oPWM,
  output logic [7:0] oPos,
  output logic [1:0] oDir,
  output logic       oBusy
);

  localparam int unsigned CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [7:0]  POS_MAX   = 8'd200;
  localparam logic [7:0]  POS_CTR   = 8'd100;
  localparam logic [7:0]  KEY_LEFT  = 8'h6B;
  localparam logic [7:0]  KEY_RIGHT = 8'h74;
  localparam logic [7:0]  KEY_NONE  = 8'h00;
  localparam logic [31:0] W_CTR     = 32'(MIN_CYC + 100 * STEP_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RAMP_L = 2'b01,
    RAMP_R = 2'b10
  } state_t;

  logic             r_rst_q;
  logic [7:0]       r_key_q;
  logic [7:0]       r_target;
  logic [7:0]       r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_width;
  logic             r_pwm;
  state_t           r_state;

  logic             w_frame_end;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       w_target_next;
  logic [7:0]       w_diff;
  logic [7:0]       w_step;
  logic [7:0]       w_pos_next;
  logic [31:0]      w_width_next;
  state_t           w_state_next;

  // Reset asserts asynchronously but releases one clock after iRST_n rises,
  // so the first count lands on the second rising edge after release.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_rst_q <= 1'b0;
    else         r_rst_q <= 1'b1;
  end

  assign w_frame_end = (r_cnt == CNT_W'(FRAME_CYC - 1));
  assign w_cnt_next  = w_frame_end ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_target_next = r_target;
    case (r_key_q)
      KEY_LEFT:  w_target_next = '0;
      KEY_RIGHT: w_target_next = POS_MAX;
      KEY_NONE:  w_target_next = POS_CTR;
      default:   w_target_next = r_target;
    endcase
  end

  // The step uses the registered target, so a key change landing on
  // frame_end only takes effect at the following frame_end.
  always_comb begin
    w_pos_next = r_pos;
    w_diff     = '0;
    if (r_target > r_pos) w_diff = r_target - r_pos;
    else                  w_diff = r_pos - r_target;
    w_step = (32'(w_diff) > RAMP_STEP) ? 8'(RAMP_STEP) : w_diff;
    if (w_frame_end) begin
      if (r_target > r_pos)      w_pos_next = r_pos + w_step;
      else if (r_target < r_pos) w_pos_next = r_pos - w_step;
    end
  end

  assign w_width_next = w_frame_end
                        ? (32'(MIN_CYC) + 32'(w_pos_next) * 32'(STEP_CYC))
                        : r_width;

  // State follows the values target/pos are about to take, keeping
  // oBusy exactly equal to (oPos != target) on every cycle.
  always_comb begin
    w_state_next = IDLE;
    if (w_target_next < w_pos_next)      w_state_next = RAMP_L;
    else if (w_target_next > w_pos_next) w_state_next = RAMP_R;
  end

  always_ff @(posedge iCLK or negedge r_rst_q) begin
    if (!r_rst_q) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge iCLK or negedge r_rst_q) begin
    if (!r_rst_q) begin
      r_key_q  <= '0;
      r_target <= POS_CTR;
      r_pos    <= POS_CTR;
      r_cnt    <= '0;
      r_width  <= W_CTR;
      r_pwm    <= 1'b0;
    end else begin
      r_key_q  <= iKeyCode;
      r_target <= w_target_next;
      r_pos    <= w_pos_next;
      r_cnt    <= w_cnt_next;
      r_width  <= w_width_next;
      // Compare on the incoming count/width so the registered pulse lines
      // up with frame_cnt: W high cycles from the start of each frame.
      r_pwm    <= (32'(w_cnt_next) < w_width_next);
    end
  end

  assign oPWM  = r_pwm;
  assign oPos  = r_pos;
  assign oDir  = r_state;
  assign oBusy = (r_state != IDLE);

endmodule

// File: tb/tb_keycode_servo_driver.sv
// Scoreboard bench: per-frame (position, high-cycle count) expectations are
// queued with each key stimulus and checked as every servo frame completes.
module tb_keycode_servo_driver;

  localparam int FRAME = 400;

  typedef struct {
    int pos;
    int width;
  } frame_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  frame_exp_t  q1[$];
  int          q2[$];
  int unsigned starts1 = 0;
  int unsigned pushed1 = 0;
  int unsigned done1   = 0;

  keycode_servo_driver_if u_if1 ();
  keycode_servo_driver_if u_if2 ();

  keycode_servo_driver #(
    .FRAME_CYC(400), .MIN_CYC(50), .STEP_CYC(1), .RAMP_STEP(4)
  ) u_dut (
    .iCLK(clk), .iRST_n(rst_n), .iKeyCode(u_if1.iKeyCode),
    .oPWM(u_if1.oPWM), .oPos(u_if1.oPos), .oDir(u_if1.oDir), .oBusy(u_if1.oBusy)
  );

  keycode_servo_driver #(
    .FRAME_CYC(400), .MIN_CYC(50), .STEP_CYC(1), .RAMP_STEP(7)
  ) u_dut7 (
    .iCLK(clk), .iRST_n(rst_n), .iKeyCode(u_if2.iKeyCode),
    .oPWM(u_if2.oPWM), .oPos(u_if2.oPos), .oDir(u_if2.oDir), .oBusy(u_if2.oBusy)
  );

  initial forever #5 clk = ~clk;

  // Frame monitor for the RAMP_STEP=4 instance
  logic       m_prev_pwm = 1'b0;
  bit         m_in_frame = 1'b0;
  bit         m_chk      = 1'b0;
  int         m_hi       = 0;
  int         m_len      = 0;
  int         m_pos      = 0;
  frame_exp_t m_exp;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_in_frame = 1'b0;
      m_chk      = 1'b0;
      m_prev_pwm = 1'b0;
    end else begin
      if (u_if1.oPWM && !m_prev_pwm) begin
        if (m_in_frame && m_chk) begin
          n_checks += 3;
          if (m_pos !== m_exp.pos) begin
            n_fail++;
            $display("FAIL frame_pos: got %0d expected %0d", m_pos, m_exp.pos);
          end
          if (m_hi !== m_exp.width) begin
            n_fail++;
            $display("FAIL frame_width (pos %0d): got %0d expected %0d", m_exp.pos, m_hi, m_exp.width);
          end
          if (m_len !== FRAME) begin
            n_fail++;
            $display("FAIL frame_length: got %0d expected %0d", m_len, FRAME);
          end
          done1++;
        end
        m_in_frame = 1'b1;
        m_hi       = 0;
        m_len      = 0;
        m_pos      = int'(u_if1.oPos);
        starts1++;
        m_chk = (q1.size() > 0);
        if (m_chk) m_exp = q1.pop_front();
      end
      if (m_in_frame) begin
        m_len++;
        if (u_if1.oPWM) m_hi++;
      end
      m_prev_pwm = u_if1.oPWM;
    end
  end

  // Position-change monitor for the RAMP_STEP=7 instance
  int m2_prev = 100;
  int m2_exp  = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m2_prev = int'(u_if2.oPos);
    end else if (int'(u_if2.oPos) != m2_prev) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL pos7_unexpected: got %0d expected no change from %0d", u_if2.oPos, m2_prev);
      end else begin
        m2_exp = q2.pop_front();
        if (int'(u_if2.oPos) !== m2_exp) begin
          n_fail++;
          $display("FAIL pos7_step: got %0d expected %0d", u_if2.oPos, m2_exp);
        end
      end
      m2_prev = int'(u_if2.oPos);
    end
  end

  task automatic wait_start(output bit ok);
    int unsigned s0;
    s0 = starts1;
    ok = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (starts1 != s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done1 == pushed1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first_hi;
    int first_lo;
    u_if1.iKeyCode = 8'h00;
    u_if2.iKeyCode = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (u_if1.oPWM !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", u_if1.oPWM); end
    if (u_if1.oPos !== 8'd100) begin n_fail++; $display("FAIL reset_pos: got %0d expected 100", u_if1.oPos); end
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b expected 00", u_if1.oDir); end
    if (u_if1.oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", u_if1.oBusy); end
    if (u_if2.oPos !== 8'd100) begin n_fail++; $display("FAIL reset_pos7: got %0d expected 100", u_if2.oPos); end
    rst_n    = 1'b1;
    first_hi = 0;
    first_lo = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (first_hi == 0 && u_if1.oPWM) first_hi = j;
      else if (first_hi != 0 && first_lo == 0 && !u_if1.oPWM) first_lo = j;
    end
    n_checks += 2;
    if (first_hi !== 2) begin n_fail++; $display("FAIL release_first_high_cycle: got %0d expected 2", first_hi); end
    if (first_lo !== 151) begin n_fail++; $display("FAIL release_first_low_cycle: got %0d expected 151", first_lo); end
  endtask

  task automatic test_centre();
    bit ok;
    repeat (2) begin
      q1.push_back('{pos: 100, width: 150});
      pushed1++;
    end
    wait_done(4 * FRAME, ok);
    n_checks += 3;
    if (!ok) begin n_fail++; $display("FAIL centre_timeout: got %0d frames expected %0d", done1, pushed1); end
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL centre_dir: got %b expected 00", u_if1.oDir); end
    if (u_if1.oPos !== 8'd100) begin n_fail++; $display("FAIL centre_pos: got %0d expected 100", u_if1.oPos); end
  endtask

  task automatic test_ramp_right();
    bit ok;
    wait_start(ok);
    @(negedge clk);
    u_if1.iKeyCode = 8'h74;
    @(negedge clk);
    n_checks++;
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL right_dir_early: got %b expected 00", u_if1.oDir); end
    @(negedge clk);
    n_checks += 2;
    if (u_if1.oDir !== 2'b10) begin n_fail++; $display("FAIL right_dir: got %b expected 10", u_if1.oDir); end
    if (u_if1.oBusy !== 1'b1) begin n_fail++; $display("FAIL right_busy: got %b expected 1", u_if1.oBusy); end
    for (int p = 104; p <= 200; p += 4) begin
      q1.push_back('{pos: p, width: 50 + p});
      pushed1++;
    end
    q1.push_back('{pos: 200, width: 250});
    pushed1++;
    wait_done(28 * FRAME, ok);
    n_checks += 4;
    if (!ok) begin n_fail++; $display("FAIL right_timeout: got %0d frames expected %0d", done1, pushed1); end
    if (u_if1.oPos !== 8'd200) begin n_fail++; $display("FAIL right_final_pos: got %0d expected 200", u_if1.oPos); end
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL right_final_dir: got %b expected 00", u_if1.oDir); end
    if (u_if1.oBusy !== 1'b0) begin n_fail++; $display("FAIL right_final_busy: got %b expected 0", u_if1.oBusy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_start(ok);
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (u_if1.oPWM !== 1'b0) begin n_fail++; $display("FAIL midreset_pwm: got %b expected 0", u_if1.oPWM); end
    if (u_if1.oPos !== 8'd100) begin n_fail++; $display("FAIL midreset_pos: got %0d expected 100", u_if1.oPos); end
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL midreset_dir: got %b expected 00", u_if1.oDir); end
    if (u_if1.oBusy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", u_if1.oBusy); end
    u_if1.iKeyCode = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_start(ok);
    q1.push_back('{pos: 100, width: 150});
    pushed1++;
    wait_done(3 * FRAME, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL midreset_timeout: got %0d frames expected %0d", done1, pushed1); end
    if (u_if1.oPos !== 8'd100) begin n_fail++; $display("FAIL midreset_after_pos: got %0d expected 100", u_if1.oPos); end
  endtask

  task automatic test_reversal();
    bit          ok;
    int unsigned sk;
    wait_start(ok);
    sk = starts1;
    @(negedge clk);
    u_if1.iKeyCode = 8'h74;
    for (int p = 104; p <= 120; p += 4) begin
      q1.push_back('{pos: p, width: 50 + p});
      pushed1++;
    end
    ok = 1'b0;
    for (int c = 0; c < 7 * FRAME; c++) begin
      @(negedge clk);
      if (starts1 >= sk + 5) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reversal_reach_timeout: got %0d starts expected %0d", starts1 - sk, 5); end
    @(negedge clk);
    u_if1.iKeyCode = 8'h6B;
    @(negedge clk);
    n_checks++;
    if (u_if1.oDir !== 2'b10) begin n_fail++; $display("FAIL reversal_dir_early: got %b expected 10", u_if1.oDir); end
    @(negedge clk);
    n_checks += 2;
    if (u_if1.oDir !== 2'b01) begin n_fail++; $display("FAIL reversal_dir: got %b expected 01", u_if1.oDir); end
    if (u_if1.oPos !== 8'd120) begin n_fail++; $display("FAIL reversal_hold_pos: got %0d expected 120", u_if1.oPos); end
    for (int p = 116; p >= 0; p -= 4) begin
      q1.push_back('{pos: p, width: 50 + p});
      pushed1++;
    end
    q1.push_back('{pos: 0, width: 50});
    pushed1++;
    // an unmapped key mid-ramp must leave the queued trajectory intact
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk);
      if (starts1 >= sk + 8) break;
    end
    @(negedge clk);
    u_if1.iKeyCode = 8'h12;
    wait_done(34 * FRAME, ok);
    n_checks += 4;
    if (!ok) begin n_fail++; $display("FAIL reversal_timeout: got %0d frames expected %0d", done1, pushed1); end
    if (u_if1.oPos !== 8'd0) begin n_fail++; $display("FAIL reversal_final_pos: got %0d expected 0", u_if1.oPos); end
    if (u_if1.oDir !== 2'b00) begin n_fail++; $display("FAIL reversal_final_dir: got %b expected 00", u_if1.oDir); end
    if (u_if1.oBusy !== 1'b0) begin n_fail++; $display("FAIL reversal_final_busy: got %b expected 0", u_if1.oBusy); end
  endtask

  task automatic test_ramp_step7();
    int p;
    bit ok;
    p = 100;
    while (p > 0) begin
      p = (p > 7) ? p - 7 : 0;
      q2.push_back(p);
    end
    @(negedge clk);
    u_if2.iKeyCode = 8'h6B;
    repeat (2) @(negedge clk);
    n_checks++;
    if (u_if2.oDir !== 2'b01) begin n_fail++; $display("FAIL step7_dir: got %b expected 01", u_if2.oDir); end
    ok = 1'b0;
    for (int c = 0; c < 17 * FRAME; c++) begin
      @(negedge clk);
      if (q2.size() == 0) begin ok = 1'b1; break; end
    end
    repeat (2 * FRAME + 10) @(negedge clk);
    n_checks += 4;
    if (!ok) begin n_fail++; $display("FAIL step7_timeout: got %0d pending expected 0", q2.size()); end
    if (u_if2.oPos !== 8'd0) begin n_fail++; $display("FAIL step7_final_pos: got %0d expected 0", u_if2.oPos); end
    if (u_if2.oDir !== 2'b00) begin n_fail++; $display("FAIL step7_final_dir: got %b expected 00", u_if2.oDir); end
    if (u_if2.oBusy !== 1'b0) begin n_fail++; $display("FAIL step7_final_busy: got %b expected 0", u_if2.oBusy); end
  endtask

  initial begin
    test_reset();
    test_centre();
    test_ramp_right();
    test_reset_mid();
    test_reversal();
    test_ramp_step7();
    n_checks += 2;
    if (q1.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries expected 0", q1.size()); end
    if (q2.size() != 0) begin n_fail++; $display("FAIL scoreboard7_left: got %0d entries expected 0", q2.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
